// File: rtl/ahb2apb_pkg.sv
// Shared state type and command/response word layout for the AHB->APB bridge.
package ahb2apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

  // Command word is {pwrite, paddr, pwdata}; response word is {err, rdata}.
  localparam int unsigned CMD_DATA_LSB = 0;

  function automatic int unsigned cmd_addr_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned cmd_wr_bit(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

  function automatic int unsigned rsp_err_bit(input int unsigned dw);
    return dw;
  endfunction

endpackage

// File: rtl/ahb2apb_apb_master.sv
// APB-domain master: pops one command, runs SETUP/ACCESS with a PREADY timeout,
// and pushes one {err,rdata} response per transfer.
module ahb2apb_apb_master
  import ahb2apb_pkg::*;
#(
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 32,
  parameter int unsigned TO_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_empty_i,
  input  logic [AW+DW:0]  cmd_rdata_i,
  output logic            cmd_rfifo_o,
  input  logic            rsp_full_i,
  output logic            rsp_wfifo_o,
  output logic [DW:0]     rsp_wdata_o,
  output logic [AW-1:0]   paddr_o,
  output logic            pwrite_o,
  output logic [DW-1:0]   pwdata_o,
  output logic            psel_o,
  output logic            penable_o,
  input  logic [DW-1:0]   prdata_i,
  input  logic            pready_i,
  input  logic            pslverr_i,
  output logic            busy_o
);

  localparam int unsigned     CMD_ADDR_LSB = cmd_addr_lsb(DW);
  localparam int unsigned     CMD_WR_BIT   = cmd_wr_bit(AW, DW);
  localparam int unsigned     RSP_ERR_BIT  = rsp_err_bit(DW);
  localparam logic [TO_W-1:0] TO_MAX       = '1;
  localparam logic [TO_W-1:0] TO_LAST      = TO_MAX - TO_W'(1);

  apb_state_e      state_q, state_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [DW:0]     rsp_q, rsp_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pop_q, pop_d;
  logic            busy_q, busy_d;
  logic            push_c;

  // Next-state, capture, timeout and response logic.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    cnt_d    = cnt_q;
    rsp_d    = rsp_q;
    push_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        paddr_d  = cmd_rdata_i[CMD_ADDR_LSB +: AW];
        pwrite_d = cmd_rdata_i[CMD_WR_BIT];
        pwdata_d = cmd_rdata_i[CMD_DATA_LSB +: DW];
        cnt_d    = '0;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // cnt_q holds completed ACCESS cycles; TO_LAST marks the final allowed one.
        if (cnt_q != TO_MAX) cnt_d = cnt_q + TO_W'(1);
        if (pready_i) begin
          rsp_d[RSP_ERR_BIT] = pslverr_i;
          rsp_d[DW-1:0]      = pwrite_q ? '0 : prdata_i;
          state_d            = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          rsp_d              = '0;
          rsp_d[RSP_ERR_BIT] = 1'b1;
          state_d            = ST_RESP;
        end
      end
      ST_RESP: begin
        // Push is qualified by the live full flag so it never lands on a full FIFO.
        if (!rsp_full_i) begin
          push_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d = (state_d == ST_ACCESS);
    pop_d     = (state_d == ST_SETUP);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      cnt_q     <= '0;
      rsp_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pop_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      cnt_q     <= cnt_d;
      rsp_q     <= rsp_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pop_q     <= pop_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd_rfifo_o = pop_q;
  assign rsp_wfifo_o = push_c;
  assign rsp_wdata_o = rsp_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_ahb2apb_apb_master.sv
// Scoreboard bench: FIFO and APB slave models around the DUT, responses checked by a monitor.
`timescale 1ns/1ps
module tb_ahb2apb_apb_master;

  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 32;
  localparam int unsigned TO_W   = 3;
  localparam int          TO_LEN = (1 << TO_W) - 1;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    cmd_t cmd;
    int   acc_len;
  } xfer_t;

  typedef struct {
    int            waits;
    logic [DW-1:0] rdata;
    logic          err;
  } slv_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_empty_i = 1'b1;
  logic [AW+DW:0]  cmd_rdata_i = '0;
  logic            cmd_rfifo_o;
  logic            rsp_full_i = 1'b0;
  logic            rsp_wfifo_o;
  logic [DW:0]     rsp_wdata_o;
  logic [AW-1:0]   paddr_o;
  logic            pwrite_o;
  logic [DW-1:0]   pwdata_o;
  logic            psel_o;
  logic            penable_o;
  logic [DW-1:0]   prdata_i = '0;
  logic            pready_i = 1'b0;
  logic            pslverr_i = 1'b0;
  logic            busy_o;

  cmd_t        fifo_q[$];
  xfer_t       apb_q[$];
  slv_t        slv_q[$];
  logic [DW:0] exp_q[$];

  int errors = 0;
  int checks = 0;
  bit rand_full = 1'b0;
  bit force_full = 1'b0;

  always #5 clk = ~clk;

  ahb2apb_apb_master #(.AW(AW), .DW(DW), .TO_W(TO_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_empty_i (cmd_empty_i),
    .cmd_rdata_i (cmd_rdata_i),
    .cmd_rfifo_o (cmd_rfifo_o),
    .rsp_full_i  (rsp_full_i),
    .rsp_wfifo_o (rsp_wfifo_o),
    .rsp_wdata_o (rsp_wdata_o),
    .paddr_o     (paddr_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i),
    .busy_o      (busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue one command together with its slave behaviour and expected outcome.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int w, input logic [DW-1:0] rd, input logic er);
    cmd_t        c;
    xfer_t       x;
    slv_t        s;
    logic [DW:0] r;
    c.wr = wr;
    c.addr = a;
    c.data = d;
    x.cmd = c;
    x.acc_len = (w >= TO_LEN) ? TO_LEN : w + 1;
    s.waits = w;
    s.rdata = rd;
    s.err = er;
    if (w >= TO_LEN) r = {1'b1, {DW{1'b0}}};
    else             r = {er, (wr ? {DW{1'b0}} : rd)};
    fifo_q.push_back(c);
    apb_q.push_back(x);
    slv_q.push_back(s);
    exp_q.push_back(r);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o || !cmd_empty_i) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now({"drain_timeout_", tag});
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pop"},     64'(cmd_rfifo_o), 64'(0));
    check({tag, "_push"},    64'(rsp_wfifo_o), 64'(0));
    check({tag, "_rsp"},     64'(rsp_wdata_o), 64'(0));
    check({tag, "_paddr"},   64'(paddr_o),     64'(0));
    check({tag, "_pwrite"},  64'(pwrite_o),    64'(0));
    check({tag, "_pwdata"},  64'(pwdata_o),    64'(0));
    check({tag, "_psel"},    64'(psel_o),      64'(0));
    check({tag, "_penable"}, 64'(penable_o),   64'(0));
    check({tag, "_busy"},    64'(busy_o),      64'(0));
  endtask

  // Command FIFO with registered read port: head valid one clk after empty falls or a pop.
  always @(posedge clk) begin
    if (cmd_rfifo_o && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (!cmd_empty_i && fifo_q.size() > 0) cmd_rdata_i <= fifo_q[0];
    else                                   cmd_rdata_i <= (AW+DW+1)'({$urandom, $urandom});
    cmd_empty_i <= (fifo_q.size() == 0);
  end

  // Response FIFO full flag.
  always @(posedge clk) begin
    #1;
    rsp_full_i = rand_full ? ($urandom_range(0, 3) == 0) : force_full;
  end

  // APB slave: per-transfer wait states; garbage on PRDATA/PSLVERR/PREADY when not completing.
  int   s_cyc = 0;
  slv_t s_cur;
  always @(posedge clk) begin
    #1;
    if (psel_o && penable_o) begin
      if (s_cyc == 0) begin
        if (slv_q.size() > 0) s_cur = slv_q.pop_front();
        else begin
          s_cur.waits = 0;
          s_cur.rdata = '0;
          s_cur.err = 1'b0;
        end
      end
      pready_i  = (s_cyc >= s_cur.waits);
      prdata_i  = pready_i ? s_cur.rdata : $urandom;
      pslverr_i = pready_i ? s_cur.err : 1'($urandom);
      s_cyc++;
    end else begin
      s_cyc     = 0;
      pready_i  = 1'($urandom);
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom);
    end
  end

  // Monitor: response scoreboard, APB address phase and idle-stability checks.
  xfer_t         m_cur;
  bit            m_in = 1'b0;
  int            m_acc = 0;
  bit            prev_ok = 1'b0;
  logic [AW-1:0] prev_addr;
  logic          prev_wr;
  logic [DW-1:0] prev_wd;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      m_in = 1'b0;
      m_acc = 0;
      prev_ok = 1'b0;
    end else begin
      if (rsp_wfifo_o) begin
        check("push_while_full", 64'(rsp_full_i), 64'(0));
        check("busy_at_push", 64'(busy_o), 64'(1));
        if (exp_q.size() == 0) fail_now("rsp_unexpected");
        else check("rsp_data", 64'(rsp_wdata_o), 64'(exp_q.pop_front()));
      end
      if (cmd_rfifo_o) begin
        check("pop_in_setup", 64'({psel_o, penable_o}), 64'(2'b10));
        check("pop_nonempty", 64'(cmd_empty_i), 64'(0));
      end
      if (psel_o && !penable_o) begin
        if (apb_q.size() == 0) fail_now("setup_unexpected");
        else begin
          m_cur = apb_q.pop_front();
          m_in = 1'b1;
          m_acc = 0;
          check("setup_paddr",  64'(paddr_o),  64'(m_cur.cmd.addr));
          check("setup_pwrite", 64'(pwrite_o), 64'(m_cur.cmd.wr));
          check("setup_pwdata", 64'(pwdata_o), 64'(m_cur.cmd.data));
          check("setup_pop",    64'(cmd_rfifo_o), 64'(1));
        end
      end else if (psel_o && penable_o) begin
        m_acc++;
        check("access_paddr",  64'(paddr_o),  64'(m_cur.cmd.addr));
        check("access_pwrite", 64'(pwrite_o), 64'(m_cur.cmd.wr));
        check("access_pwdata", 64'(pwdata_o), 64'(m_cur.cmd.data));
      end else begin
        if (penable_o) fail_now("penable_without_psel");
        if (m_in) begin
          check("access_len", 64'(m_acc), 64'(m_cur.acc_len));
          m_in = 1'b0;
        end
        if (prev_ok) begin
          check("idle_paddr_stable",  64'(paddr_o),  64'(prev_addr));
          check("idle_pwrite_stable", 64'(pwrite_o), 64'(prev_wr));
          check("idle_pwdata_stable", 64'(pwdata_o), 64'(prev_wd));
        end
      end
      prev_ok   = 1'b1;
      prev_addr = paddr_o;
      prev_wr   = pwrite_o;
      prev_wd   = pwdata_o;
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single write, pready tied high: push in the 5th clk counting the empty-fall clk.
    issue(1'b1, 16'h0010, 32'hA5A5_0001, 0, 32'h0, 1'b0);
    n = 0;
    while (cmd_empty_i && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!rsp_wfifo_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("write_push_latency", 64'(n), 64'(4));
    wait_idle("write");

    // Read with 3 wait states; slave error then a clean write; timeout boundaries.
    issue(1'b0, 16'h0020, $urandom, 3, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 16'h0030, $urandom, 1, 32'h1234_5678, 1'b1);
    issue(1'b1, 16'h0034, 32'h0BAD_F00D, 0, 32'h0, 1'b0);
    issue(1'b0, 16'h0040, $urandom, TO_LEN - 1, 32'hCAFE_0006, 1'b0);
    issue(1'b0, 16'h0044, $urandom, TO_LEN, 32'hCAFE_0007, 1'b0);
    issue(1'b1, 16'h0048, $urandom, 20, 32'h0, 1'b1);
    wait_idle("directed");

    // Backpressure: hold full while three commands are queued.
    force_full = 1'b1;
    issue(1'b0, 16'h0100, $urandom, 2, 32'h1111_0001, 1'b0);
    issue(1'b1, 16'h0104, $urandom, 0, 32'h0, 1'b0);
    issue(1'b0, 16'h0108, $urandom, 5, 32'h3333_0003, 1'b1);
    repeat (15) tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_no_push", 64'(rsp_wfifo_o), 64'(0));
      check("bp_no_pop",  64'(cmd_rfifo_o), 64'(0));
      check("bp_busy",    64'(busy_o),      64'(1));
      check("bp_no_psel", 64'(psel_o),      64'(0));
    end
    tick();
    force_full = 1'b0;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("bp_push_on_release", 64'(rsp_wfifo_o), 64'(1));
    wait_idle("backpressure");

    // Reset in the middle of ACCESS; aborted transfer gets no response.
    issue(1'b1, 16'h0200, 32'h5555_AAAA, 5, 32'h0, 1'b0);
    issue(1'b0, 16'h0204, $urandom, 0, 32'h7777_0204, 1'b0);
    n = 0;
    while (!(psel_o && penable_o) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("reset_test_no_access");
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_access");
    void'(exp_q.pop_front());
    tick();
    tick();
    rst_n = 1'b1;
    wait_idle("after_reset");

    // Randomized traffic with random response backpressure.
    rand_full = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int g;
      g = 0;
      while (fifo_q.size() >= 3 && g < 500) begin
        tick();
        g++;
      end
      if (g >= 500) fail_now("random_fifo_stuck");
      issue(1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 9)),
            $urandom, 1'($urandom));
      repeat ($urandom_range(0, 4)) tick();
    end
    wait_idle("random");
    rand_full = 1'b0;

    check("end_fifo_empty", 64'(fifo_q.size()), 64'(0));
    check("end_apb_q_empty", 64'(apb_q.size()), 64'(0));
    check("end_slv_q_empty", 64'(slv_q.size()), 64'(0));
    check("end_not_busy", 64'(busy_o), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
